sweep_stim_gen: RTL and testbench

//  Parametrised exhaustive stimulus sequencer with response-signature capture, for equivalence runs on

---
 rtl/sweep_stim_gen.sv | 196 +++++++++++++++++++
 tb/tb_sweep_stim_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_stim_gen.sv
// -----------------------------------------------------------------------------
// sweep_stim_gen
//   Exhaustive stimulus sequencer for equivalence runs on combinational DUTs.
//   Walks an NCH*LB-bit index through every value (nested or Gray order), and
//   splits the presented code into NCH channels of LB bits, each zero-extended
//   to W bits. Channel 0 takes the top LB bits of the code (slowest), channel
//   NCH-1 the bottom LB bits (fastest). The DUT response is folded into a MISR
//   signature so two netlists can be compared by a single word.
//
// Ports
//   clk, rst_n   bench clock (rising edge), asynchronous active-low reset
//   start        begin a sweep; honoured only in IDLE or DONE
//   mode         0 = nested order, 1 = Gray order; latched together with start
//   hold         stall the sequence while high (ignored during FLUSH)
//   resp         DUT response, OW bits
//   stim         channel c on stim[c*W +: W]
//   stim_valid   stim carries a newly issued pattern this cycle
//   busy         high in RUN or FLUSH
//   done         high in DONE
//   pattern_cnt  number of patterns issued since start
//   signature    MISR value
//   state_dbg    current FSM state (IDLE=0, RUN=1, FLUSH=2, DONE=3)
//
// Flow control: stim_valid is a one-cycle qualifier with no ready. A pattern
// is issued on every RUN edge where hold is low; the pattern is visible on
// stim with stim_valid=1 in the following cycle. With hold high no pattern is
// issued, stim keeps its previous value and stim_valid is 0 the next cycle.
// The response for the pattern shown in cycle X must be on resp in cycle
// X+RESP_LAT; it is folded on the edge closing that cycle.
// -----------------------------------------------------------------------------
module sweep_stim_gen #(
  parameter int               NCH      = 3,
  parameter int               W        = 19,
  parameter int               LB       = 4,
  parameter int               OW       = 20,
  parameter int               SIG_W    = 32,
  parameter logic [SIG_W-1:0] POLY     = SIG_W'(32'h04C11DB7),
  parameter int               RESP_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 hold,
  input  logic [OW-1:0]        resp,
  output logic [NCH*W-1:0]     stim,
  output logic                 stim_valid,
  output logic                 busy,
  output logic                 done,
  output logic [NCH*LB:0]      pattern_cnt,
  output logic [SIG_W-1:0]     signature,
  output logic [1:0]           state_dbg
);

  localparam int IW = NCH * LB;
  // Pipeline is at least one bit wide so the RESP_LAT=0 build still elaborates.
  localparam int PW = (RESP_LAT > 0) ? RESP_LAT : 1;
  localparam logic [IW-1:0] I_LAST = '1;
  localparam logic [2:0] FLUSH_INIT = (RESP_LAT > 0) ? 3'(RESP_LAT - 1) : 3'd0;
  localparam bit LAT0 = (RESP_LAT == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 mode_q, mode_d;
  logic [NCH*W-1:0]     stim_q, stim_d;
  logic                 stim_valid_q, stim_valid_d;
  logic [IW:0]          cnt_q, cnt_d;
  logic [SIG_W-1:0]     sig_q, sig_d;
  logic [PW-1:0]        vpipe_q, vpipe_d;
  logic [2:0]           flush_q, flush_d;

  logic [IW-1:0]        code;
  logic [NCH*W-1:0]     stim_word;
  logic                 v_d;
  logic [SIG_W-1:0]     sig_next;

  // Presented code: binary index, or its reflected Gray code.
  always_comb begin
    code = mode_q ? (idx_q ^ (idx_q >> 1)) : idx_q;
  end

  // Channel 0 takes the most significant LB bits of the code.
  always_comb begin
    stim_word = '0;
    for (int c = 0; c < NCH; c++) begin
      stim_word[c*W +: W] = W'(code[(NCH-1-c)*LB +: LB]);
    end
  end

  // stim_valid delayed to line up with the DUT response.
  always_comb begin
    v_d = LAT0 ? stim_valid_q : vpipe_q[PW-1];
  end

  // MISR step: shift left (MSB dropped), feedback on the old MSB, inject resp.
  always_comb begin
    sig_next = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ SIG_W'(resp);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mode_d       = mode_q;
    stim_d       = stim_q;
    stim_valid_d = 1'b0;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    vpipe_d      = PW'(vpipe_q << 1) | PW'(stim_valid_q);
    sig_d        = v_d ? sig_next : sig_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = '0;
          sig_d   = '0;
          mode_d  = mode;
          // Drop anything still in flight so the new signature starts clean.
          vpipe_d = '0;
        end
      end
      S_RUN: begin
        if (!hold) begin
          stim_d       = stim_word;
          stim_valid_d = 1'b1;
          cnt_d        = cnt_q + (IW+1)'(1);
          idx_d        = idx_q + IW'(1);
          if (idx_q == I_LAST) begin
            if (LAT0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FLUSH;
              flush_d = FLUSH_INIT;
            end
          end
        end
      end
      S_FLUSH: begin
        // Runs exactly RESP_LAT cycles regardless of hold.
        if (flush_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          flush_d = flush_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      mode_q       <= 1'b0;
      stim_q       <= '0;
      stim_valid_q <= 1'b0;
      cnt_q        <= '0;
      sig_q        <= '0;
      vpipe_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      stim_q       <= stim_d;
      stim_valid_q <= stim_valid_d;
      cnt_q        <= cnt_d;
      sig_q        <= sig_d;
      vpipe_q      <= vpipe_d;
      flush_q      <= flush_d;
    end
  end

  always_comb begin
    stim        = stim_q;
    stim_valid  = stim_valid_q;
    busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
    done        = (state_q == S_DONE);
    pattern_cnt = cnt_q;
    signature   = sig_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_sweep_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_sweep_stim_gen
//   Two instances share the control inputs: u_dut0 (RESP_LAT=0) driven by a
//   combinational response function, u_dut3 (RESP_LAT=3) driven by the same
//   function behind three registers. Expected patterns come from a table of
//   hand-computed channel values plus a small index/code model; expected
//   signatures come from a bench-side MISR model walked over all 4096 codes.
// -----------------------------------------------------------------------------
module tb_sweep_stim_gen;

  localparam int NCH = 3;
  localparam int W   = 19;
  localparam int LB  = 4;
  localparam int OW  = 20;
  localparam int SW  = NCH * W;
  localparam int NP  = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0;
  logic mode  = 1'b0;
  logic hold  = 1'b0;

  logic [OW-1:0]     resp0, resp3;
  logic [SW-1:0]     stim0, stim3;
  logic              stim_valid0, stim_valid3;
  logic              busy0, busy3, done0, done3;
  logic [NCH*LB:0]   pcnt0, pcnt3;
  logic [31:0]       sig0, sig3;
  logic [1:0]        st0, st3;

  sweep_stim_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold(hold),
    .resp(resp0), .stim(stim0), .stim_valid(stim_valid0), .busy(busy0),
    .done(done0), .pattern_cnt(pcnt0), .signature(sig0), .state_dbg(st0)
  );

  sweep_stim_gen #(.RESP_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold(hold),
    .resp(resp3), .stim(stim3), .stim_valid(stim_valid3), .busy(busy3),
    .done(done3), .pattern_cnt(pcnt3), .signature(sig3), .state_dbg(st3)
  );

  // ---------------- models ----------------
  int   resp_kind = 0;   // 0: mixing function, 1: tied zero, 2: one on pattern 0 only
  logic mon_mode  = 1'b0;

  function automatic logic [SW-1:0] code_word(input logic m, input int k);
    logic [11:0] i, c;
    logic [SW-1:0] w;
    i = 12'(k);
    c = m ? (i ^ (i >> 1)) : i;
    w = '0;
    w[18:0]  = 19'(c[11:8]);
    w[37:19] = 19'(c[7:4]);
    w[56:38] = 19'(c[3:0]);
    return w;
  endfunction

  function automatic logic [OW-1:0] dut_f(input logic [SW-1:0] s);
    int a, b, c;
    a = int'(s[18:0]);
    b = int'(s[37:19]);
    c = int'(s[56:38]);
    return 20'((a * b * 13) + (c * 977) + ((a ^ c) << 12) + b);
  endfunction

  function automatic logic [OW-1:0] resp_fn(input int kind, input logic [SW-1:0] s, input logic v);
    if (kind == 0) return dut_f(s);
    if (kind == 1) return '0;
    return (v && s == '0) ? 20'd1 : 20'd0;
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [OW-1:0] r);
    logic [31:0] t;
    t = {s[30:0], 1'b0};
    if (s[31]) t = t ^ 32'h04C11DB7;
    return t ^ {12'd0, r};
  endfunction

  function automatic logic [31:0] gold_sig(input logic m, input int kind);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < NP; k++) s = misr(s, resp_fn(kind, code_word(m, k), 1'b1));
    return s;
  endfunction

  always_comb resp0 = resp_fn(resp_kind, stim0, stim_valid0);

  logic [OW-1:0] dl0, dl1, dl2;
  always @(posedge clk) begin
    dl0 <= resp_fn(resp_kind, stim3, stim_valid3);
    dl1 <= dl0;
    dl2 <= dl1;
  end
  assign resp3 = dl2;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       m;
    int         idx;
    logic [3:0] c0, c1, c2;
  } vec_t;
  vec_t vecs[8];

  // Monitor: every issued pattern is checked against the code model, Gray
  // sweeps against the one-bit-step rule, table entries against hand values.
  int k = 0;
  int stim_err = 0, gray_err = 0, lock_err = 0;
  logic [SW-1:0] prev = '0;
  logic [SW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (stim_valid0) begin
      exp_q.push_back(code_word(mon_mode, k));
      if (stim0 !== exp_q.pop_front()) stim_err++;
      if (mon_mode && k > 0 && $countones(stim0 ^ prev) != 1) gray_err++;
      for (int i = 0; i < 8; i++) begin
        if (vecs[i].m == mon_mode && vecs[i].idx == k)
          chk($sformatf("vec_m%0d_p%0h", vecs[i].m, vecs[i].idx), 64'(stim0),
              64'({15'd0, vecs[i].c2, 15'd0, vecs[i].c1, 15'd0, vecs[i].c0}));
      end
      prev = stim0;
      k++;
    end else if (!busy0) begin
      k = 0;
    end
    if (stim0 !== stim3 || stim_valid0 !== stim_valid3) lock_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic chk_reset(input string tag);
    chk({tag, "_stim0"},  64'(stim0), 64'd0);
    chk({tag, "_valid0"}, 64'(stim_valid0), 64'd0);
    chk({tag, "_busy0"},  64'(busy0), 64'd0);
    chk({tag, "_done0"},  64'(done0), 64'd0);
    chk({tag, "_cnt0"},   64'(pcnt0), 64'd0);
    chk({tag, "_sig0"},   64'(sig0), 64'd0);
    chk({tag, "_state0"}, 64'(st0), 64'd0);
    chk({tag, "_stim3"},  64'(stim3), 64'd0);
    chk({tag, "_sig3"},   64'(sig3), 64'd0);
    chk({tag, "_state3"}, 64'(st3), 64'd0);
  endtask

  // One full sweep on both instances. hold_at >= 0 holds for 5 cycles while
  // pattern #hold_at is shown. Also pulses start (with the other mode) while
  // busy, and raises hold during the RESP_LAT=3 flush.
  task automatic run_sweep(input string tag, input logic m, input int kind, input int hold_at);
    int n, cnt, t0, t3, exp_t0;
    logic [SW-1:0] w;
    logic sig1_pend;
    logic frz_ok;
    resp_kind = kind;
    mon_mode  = m;
    exp_t0    = NP + ((hold_at >= 0) ? 5 : 0);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    chk({tag, "_busy_after_start"}, 64'({busy0, done0, busy3}), 64'(3'b101));
    n = 0; cnt = 0; t0 = -1; t3 = -1; sig1_pend = 1'b0; frz_ok = 1'b1;
    while (t3 < 0 && n < 6000) begin
      if (stim_valid0) cnt++;
      if (sig1_pend) begin
        chk({tag, "_sig_after_p0"}, 64'(sig0), 64'd1);
        sig1_pend = 1'b0;
      end
      if (kind == 2 && stim_valid0 && cnt == 1) sig1_pend = 1'b1;
      if (done0 && t0 < 0) begin
        t0   = n;
        hold = 1'b1;
      end
      if (done3 && t3 < 0) t3 = n;
      start = stim_valid0 && (cnt == 100);
      if (stim_valid0 && cnt == hold_at + 1) begin
        w    = stim0;
        hold = 1'b1;
        repeat (5) begin
          @(negedge clk);
          n++;
          if (stim_valid0 !== 1'b0 || stim0 !== w) frz_ok = 1'b0;
        end
        hold = 1'b0;
        chk({tag, "_hold_frozen"}, 64'(frz_ok), 64'd1);
      end
      if (t3 < 0) begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    if (t3 < 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done0_at=%0d done3_at=%0d limit=6000", tag, t0, t3);
    end
    chk({tag, "_done0_cycles"}, 64'(t0), 64'(exp_t0));
    chk({tag, "_done3_cycles"}, 64'(t3), 64'(exp_t0 + 3));
    repeat (2) @(negedge clk);
    chk({tag, "_cnt0"}, 64'(pcnt0), 64'(NP));
    chk({tag, "_cnt3"}, 64'(pcnt3), 64'(NP));
    chk({tag, "_flags0"}, 64'({busy0, done0, st0}), 64'({1'b0, 1'b1, 2'd3}));
    chk({tag, "_last_stim"}, 64'(stim0), 64'(code_word(m, NP - 1)));
    chk({tag, "_sig0"}, 64'(sig0), 64'(gold_sig(m, kind)));
    chk({tag, "_sig3"}, 64'(sig3), 64'(gold_sig(m, kind)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, cnt;
    vecs[0] = '{1'b0, 'h123, 4'h1, 4'h2, 4'h3};
    vecs[1] = '{1'b0, 'h000, 4'h0, 4'h0, 4'h0};
    vecs[2] = '{1'b0, 'hFFF, 4'hF, 4'hF, 4'hF};
    vecs[3] = '{1'b0, 'h0A5, 4'h0, 4'hA, 4'h5};
    vecs[4] = '{1'b1, 'h002, 4'h0, 4'h0, 4'h3};
    vecs[5] = '{1'b1, 'hFFF, 4'h8, 4'h0, 4'h0};
    vecs[6] = '{1'b1, 'h123, 4'h1, 4'hB, 4'h2};
    vecs[7] = '{1'b1, 'h00A, 4'h0, 4'h0, 4'hF};

    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("idle");

    run_sweep("nested",  1'b0, 0, -1);
    run_sweep("gray",    1'b1, 0, -1);
    run_sweep("hold",    1'b0, 0, 10);
    run_sweep("resp0",   1'b0, 1, -1);
    run_sweep("resp_p0", 1'b0, 2, -1);

    // Reset in the middle of a sweep, while pattern #2000 is shown.
    resp_kind = 0;
    mon_mode  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0; cnt = 0;
    while (n < 5000) begin
      if (stim_valid0) cnt++;
      if (cnt == 2001) break;
      @(negedge clk);
      n++;
    end
    chk("midrun_cnt", 64'(pcnt0), 64'd2001);
    #1 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("after_rst");
    run_sweep("post_rst", 1'b0, 0, -1);

    chk("stim_sequence_errors", 64'(stim_err), 64'd0);
    chk("gray_step_errors",     64'(gray_err), 64'd0);
    chk("lat3_lockstep_errors", 64'(lock_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
